// File: rtl/mem_issue_queue_pkg.sv
// Shared types for the in-order memory-op issue queue: default widths,
// queue entry layout, CDB broadcast payload and the effective-address helper.
package mem_issue_queue_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned IQ_DEPTH = 8;

  typedef struct packed {
    logic              valid;
    logic              is_ld;
    logic              base_rdy;
    logic [DATA_W-1:0] base;
    logic              sd_rdy;
    logic [DATA_W-1:0] sd;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  rob;
  } iq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bcast_t;

  // Carry out of the add is intentionally dropped.
  function automatic logic [DATA_W-1:0] eff_addr(input iq_entry_t e);
    return e.base + e.imm;
  endfunction

endpackage

// File: rtl/mem_issue_queue_if.sv
// Dispatch, CDB snoop and load_store_unit issue signals of mem_issue_queue.
// master = dispatch/CDB/LSU side, slave = the queue.
interface mem_issue_queue_if
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) ();

  logic                     disp_valid;
  logic                     disp_ready;
  logic                     disp_is_ld;
  logic                     disp_base_rdy;
  logic [DATA_W-1:0]        disp_base;
  logic                     disp_sd_rdy;
  logic [DATA_W-1:0]        disp_sd;
  logic [DATA_W-1:0]        disp_imm;
  logic [TAG_W-1:0]         disp_rob;

  logic                     cdb0_valid;
  logic [TAG_W-1:0]         cdb0_tag;
  logic [DATA_W-1:0]        cdb0_data;
  logic                     cdb1_valid;
  logic [TAG_W-1:0]         cdb1_tag;
  logic [DATA_W-1:0]        cdb1_data;

  logic                     load_stall;
  logic                     is_ld;
  logic [DATA_W-1:0]        data;
  logic [DATA_W-1:0]        location;
  logic [TAG_W-1:0]         ROBloc;
  logic                     input_valid;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output disp_valid, disp_is_ld, disp_base_rdy, disp_base, disp_sd_rdy,
           disp_sd, disp_imm, disp_rob,
           cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
           load_stall,
    input  disp_ready, is_ld, data, location, ROBloc, input_valid, count
  );

  modport slave (
    input  disp_valid, disp_is_ld, disp_base_rdy, disp_base, disp_sd_rdy,
           disp_sd, disp_imm, disp_rob,
           cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
           load_stall,
    output disp_ready, is_ld, data, location, ROBloc, input_valid, count
  );

endinterface

// File: rtl/mem_issue_queue_operand_snoop.sv
// Per-operand CDB wakeup: an enabled, unready operand whose tag matches a valid
// broadcast takes that broadcast's value; cdb0 wins when both ports match.
module mem_issue_queue_operand_snoop
  import mem_issue_queue_pkg::*;
(
  input  logic              en_i,
  input  logic              rdy_i,
  input  logic [DATA_W-1:0] val_i,
  input  cdb_bcast_t        cdb0_i,
  input  cdb_bcast_t        cdb1_i,
  output logic              rdy_c_o,
  output logic [DATA_W-1:0] val_c_o
);

  logic [TAG_W-1:0] tag;
  logic             hit0;
  logic             hit1;

  assign tag  = val_i[TAG_W-1:0];
  assign hit0 = en_i && !rdy_i && cdb0_i.valid && (cdb0_i.tag == tag);
  assign hit1 = en_i && !rdy_i && cdb1_i.valid && (cdb1_i.tag == tag);

  assign rdy_c_o = rdy_i | hit0 | hit1;
  assign val_c_o = hit0 ? cdb0_i.data :
                   hit1 ? cdb1_i.data : val_i;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue feeding load_store_unit, with CDB operand wakeup.
// Build option MEM_IQ_BYPASS_EN: the head also sees same-cycle CDB wakeups and issues a cycle earlier.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  mem_issue_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t         ent_q   [DEPTH];
  iq_entry_t         ent_d   [DEPTH];
  iq_entry_t         ent_snp [DEPTH];
  logic              base_rdy_s [DEPTH];
  logic [DATA_W-1:0] base_s     [DEPTH];
  logic              sd_rdy_s   [DEPTH];
  logic [DATA_W-1:0] sd_s       [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              is_ld_q, is_ld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] loc_q, loc_d;
  logic [TAG_W-1:0]  rob_q, rob_d;
  logic              valid_q, valid_d;

  cdb_bcast_t        cdb0, cdb1;
  iq_entry_t         disp_ent;
  iq_entry_t         head_c;
  logic              disp_base_rdy_c, disp_sd_rdy_c;
  logic [DATA_W-1:0] disp_base_c, disp_sd_c;
  logic              disp_ready_c;
  logic              enq_c;
  logic              iss_c;

  assign cdb0 = cdb_bcast_t'{valid: bus.cdb0_valid, tag: bus.cdb0_tag, data: bus.cdb0_data};
  assign cdb1 = cdb_bcast_t'{valid: bus.cdb1_valid, tag: bus.cdb1_tag, data: bus.cdb1_data};

  // Readiness depends on occupancy only, never on a same-cycle issue.
  assign disp_ready_c = (count_q < CNT_W'(DEPTH));
  assign enq_c        = bus.disp_valid && disp_ready_c;

  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    mem_issue_queue_operand_snoop u_base (
      .en_i    (ent_q[i].valid),
      .rdy_i   (ent_q[i].base_rdy),
      .val_i   (ent_q[i].base),
      .cdb0_i  (cdb0),
      .cdb1_i  (cdb1),
      .rdy_c_o (base_rdy_s[i]),
      .val_c_o (base_s[i])
    );
    mem_issue_queue_operand_snoop u_sd (
      .en_i    (ent_q[i].valid),
      .rdy_i   (ent_q[i].sd_rdy),
      .val_i   (ent_q[i].sd),
      .cdb0_i  (cdb0),
      .cdb1_i  (cdb1),
      .rdy_c_o (sd_rdy_s[i]),
      .val_c_o (sd_s[i])
    );
  end

  // Dispatch path snoop so a broadcast in the enqueue cycle is not lost.
  mem_issue_queue_operand_snoop u_disp_base (
    .en_i    (1'b1),
    .rdy_i   (bus.disp_base_rdy),
    .val_i   (bus.disp_base),
    .cdb0_i  (cdb0),
    .cdb1_i  (cdb1),
    .rdy_c_o (disp_base_rdy_c),
    .val_c_o (disp_base_c)
  );

  mem_issue_queue_operand_snoop u_disp_sd (
    .en_i    (1'b1),
    .rdy_i   (bus.disp_sd_rdy | bus.disp_is_ld),
    .val_i   (bus.disp_sd),
    .cdb0_i  (cdb0),
    .cdb1_i  (cdb1),
    .rdy_c_o (disp_sd_rdy_c),
    .val_c_o (disp_sd_c)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_snp[i]          = ent_q[i];
      ent_snp[i].base_rdy = base_rdy_s[i];
      ent_snp[i].base     = base_s[i];
      ent_snp[i].sd_rdy   = sd_rdy_s[i];
      ent_snp[i].sd       = sd_s[i];
    end
  end

  always_comb begin
    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.is_ld    = bus.disp_is_ld;
    disp_ent.base_rdy = disp_base_rdy_c;
    disp_ent.base     = disp_base_c;
    disp_ent.sd_rdy   = disp_sd_rdy_c;
    disp_ent.sd       = disp_sd_c;
    disp_ent.imm      = bus.disp_imm;
    disp_ent.rob      = bus.disp_rob;
  end

`ifdef MEM_IQ_BYPASS_EN
  assign head_c = ent_snp[head_q];
`else
  assign head_c = ent_q[head_q];
`endif

  // Only the head may issue; a blocked head holds back every younger op.
  assign iss_c = head_c.valid && head_c.base_rdy && head_c.sd_rdy && !bus.load_stall;

  always_comb begin
    ent_d   = ent_snp;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    is_ld_d = is_ld_q;
    data_d  = data_q;
    loc_d   = loc_q;
    rob_d   = rob_q;
    valid_d = 1'b0;

    if (iss_c) begin
      ent_d[head_q].valid = 1'b0;
      head_d  = head_q + PTR_W'(1);
      is_ld_d = head_c.is_ld;
      data_d  = head_c.is_ld ? '0 : head_c.sd;
      loc_d   = eff_addr(head_c);
      rob_d   = head_c.rob;
      valid_d = 1'b1;
    end

    // Never collides with the issuing slot: enqueue needs a free tail entry.
    if (enq_c) begin
      ent_d[tail_q] = disp_ent;
      tail_d        = tail_q + PTR_W'(1);
    end

    case ({enq_c, iss_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      is_ld_q <= 1'b0;
      data_q  <= '0;
      loc_q   <= '0;
      rob_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      is_ld_q <= is_ld_d;
      data_q  <= data_d;
      loc_q   <= loc_d;
      rob_q   <= rob_d;
      valid_q <= valid_d;
    end
  end

  assign bus.disp_ready  = disp_ready_c;
  assign bus.is_ld       = is_ld_q;
  assign bus.data        = data_q;
  assign bus.location    = loc_q;
  assign bus.ROBloc      = rob_q;
  assign bus.input_valid = valid_q;
  assign bus.count       = count_q;

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order memory-op issue queue directly upstream of load_store_unit.
- Accepts loads/stores from dispatch with possibly-unready base and store-data operands, and snoops the CDB for ROB-tag broadcasts.
- Computes the effective address (base+imm) and issues one op per cycle, strictly in program order, on the is_ld/data/location/ROBloc/input_valid interface of load_store_unit.
- Honours load_stall backpressure.

Parameters:
DEPTH, 8, queue entries; must be a power of two, 2..16.
TAG_W, 6, ROB tag width; matches ROBloc.
DATA_W, 16, data/address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  mispredict flush; synchronous, same effect as reset on queue state
disp_valid  in  1  dispatch offers an op
disp_ready  out  1  queue can accept (count < DEPTH)
disp_is_ld  in  1  1=load, 0=store
disp_base_rdy  in  1  base operand value valid
disp_base  in  DATA_W  base value, or tag in [TAG_W-1:0] when not ready
disp_sd_rdy  in  1  store-data value valid (ignored for loads)
disp_sd  in  DATA_W  store-data value, or tag when not ready
disp_imm  in  DATA_W  address offset
disp_rob  in  TAG_W  ROB location of the op
cdb0_valid, cdb1_valid  in  1  CDB broadcast valid
cdb0_tag, cdb1_tag  in  TAG_W  broadcast ROB tag
cdb0_data, cdb1_data  in  DATA_W  broadcast value
load_stall  in  1  from load_store_unit; blocks issue
is_ld  out  1  issued op is a load
data  out  DATA_W  store data (0 for loads)
location  out  DATA_W  effective address
ROBloc  out  TAG_W  issued op ROB location
input_valid  out  1  issue strobe, one cycle per op
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset or flush: head=tail=count=0, all entry valid bits cleared, input_valid=0, is_ld=0, data=location=0, ROBloc=0.
- disp_ready=1 after reset.
- Flush has priority over dispatch, snoop and issue that cycle; the flushed-cycle dispatch is dropped.
- Enqueue: on the clk edge when disp_valid && disp_ready, the entry is written at tail, tail=(tail+1) mod DEPTH.
- For loads the sd operand is forced ready.
- Snoop: every cycle, each valid entry with an unready operand whose tag equals a valid cdbN_tag captures cdbN_data and sets that operand ready.
- If both ports match the same tag, cdb0 wins.
- Enqueue-cycle snoop: a dispatched unready operand matching a same-cycle CDB broadcast is captured on write. No lost wakeups.
- Issue rule: the head is eligible when its entry is valid, base ready and sd ready, and load_stall=0.
- On issue, the output registers load at the edge: location=(base+imm) mod 2^DATA_W (carry dropped), data=sd (0 for loads), is_ld, ROBloc, input_valid=1.
- On issue, head advances mod DEPTH.
- Otherwise input_valid=0 and the other outputs hold.
- No younger op bypasses a blocked head: a store waiting on data also blocks later loads.
- Latency: an op dispatched with ready operands at edge E0 is issued at edge E1, so input_valid is high in the cycle after E1.
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- Full: disp_ready=0; dispatch offered while full is not accepted and disp_* must be held.
- Empty: no issue. Pointer wrap at DEPTH-1 → 0.
- disp_ready is combinational from count only, not from same-cycle issue. A full queue issuing this cycle still shows disp_ready=0.
- Reset/flush mid-operation discards all entries, including ones partially woken.

Optional Feature:
MEM_IQ_BYPASS_EN
- Defined: the head's operand readiness and value also include same-cycle CDB matches. A head woken by the CDB in cycle N issues at the end of cycle N, saving one cycle.
- Undefined: woken operands are used only from the next cycle, and issue is one cycle later.
- Issue order and all other behaviour are identical in both builds.

Decomposition:
- Shared package mem_pkg holds DATA_W/TAG_W defaults and an entry typedef: valid, is_ld, base_rdy, base, sd_rdy, sd, imm, rob.
- The package also holds a cdb_bcast typedef: valid, tag, data.
- One sub-module is natural: operand_snoop. It is per operand: it compares rdy/tag against both CDB ports and produces next rdy/value with cdb0 priority. It is instantiated 2×DEPTH plus the dispatch path.

Test Plan:
- Load, base ready=0x1000, imm=0x0010, rob=5 → one cycle later: input_valid=1, is_ld=1, location=0x1010, ROBloc=5, data=0.
- Store at rob 3 with sd tag 9 unready, then load at rob 4 ready; cdb0 tag 9 data 0xBEEF two cycles later → store issues first with data=0xBEEF, load issues the following cycle.
  - Check the store-issue cycle with and without MEM_IQ_BYPASS_EN.
- Fill 8 ready ops with load_stall=1 → count=8, disp_ready=0, no input_valid. Release load_stall → 8 consecutive issues in order; wrap-around verified by a second batch.
- Address overflow: base=0xFFF0, imm=0x0020 → location=0x0010.
- Same-tag broadcast on cdb0 (0x1111) and cdb1 (0x2222) matching a waiting base → captured value 0x1111.
- Dispatch an unready op coinciding with its tag on cdb1 → op issues normally.
- Flush asserted with 4 entries plus a same-cycle dispatch → next cycle count=0, input_valid=0, and the dropped op never issues.
